// File: rtl/spiker_pkg.sv
// Shared types and helpers for the spike feeder and its input FIFO.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package spiker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } feeder_state_t;

    // Pointer index width for a power-of-two FIFO depth; full/empty adds one MSB on top.
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/spike_fifo.sv
// Generic synchronous FIFO with wrap-around pointers and an occupancy count.
// Latency: a push into an empty FIFO is visible at pop_dat the next cycle.
// Backpressure: pushes while full are dropped; pops while empty are ignored.
module spike_fifo
    import spiker_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 8,
    localparam int AW   = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic [AW:0]   count
);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         full;
    logic         empty;
    logic         do_push;
    logic         do_pop;

    // Same index with differing wrap bits means the writer is a full lap ahead.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = wr_ptr - rd_ptr;
    assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/spike_feeder.sv
// Feeds queued spike vectors to the network one frame at a time and tallies output spikes.
// Latency: push->net_sample_ready 1 cycle; start condition->net_start 1 cycle.
// Backpressure: wr_ready drops when the FIFO is full; samples on an empty FIFO flag underrun.
module spike_feeder
    import spiker_pkg::*;
#(
    parameter int N_IN      = 4,
    parameter int N_OUT     = 2,
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 3,
    parameter int CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    input  logic [N_IN-1:0]        wr_data,
    output logic                   wr_ready,
    input  logic                   net_ready,
    input  logic                   net_sample,
    input  logic [N_OUT-1:0]       net_out_spikes,
    output logic                   net_start,
    output logic                   net_sample_ready,
    output logic [N_IN-1:0]        net_in_spikes,
    output logic                   frame_done,
    output logic [N_OUT*CNT_W-1:0] spike_cnt,
    output logic                   underrun
);

    localparam int AW = ptr_w(DEPTH);
    localparam int SW = $clog2(FRAME_LEN + 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [SW-1:0] LAST_IDX = SW'(FRAME_LEN - 1);

    feeder_state_t    state;
    feeder_state_t    state_nxt;
    logic [AW:0]      fifo_cnt;
    logic             fifo_empty;
    logic             start_run;
    logic             take;
    logic             starve;
    logic             frame_end;
    logic [SW-1:0]    sample_cnt;
    logic [CNT_W-1:0] cnt [N_OUT];

    assign fifo_empty       = (fifo_cnt == '0);
    assign wr_ready         = (fifo_cnt != FULL_CNT);
    assign net_sample_ready = !fifo_empty;

    assign start_run = (state == IDLE) && net_ready && !fifo_empty;
    assign take      = (state == RUN) && net_sample && !fifo_empty;
    assign starve    = (state == RUN) && net_sample && fifo_empty;
    assign frame_end = take && (sample_cnt == LAST_IDX);

    spike_fifo #(
        .W     (N_IN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (wr_valid),
        .push_dat (wr_data),
        .pop      (take),
        .pop_dat  (net_in_spikes),
        .count    (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_run) state_nxt = RUN;
            RUN:     if (frame_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        net_start  = 1'b0;
        frame_done = 1'b0;
        case (state)
            RUN:     net_start  = 1'b1;
            DONE:    frame_done = 1'b1;
            default: ;
        endcase
    end

    // Counts stay frozen after a frame so the host can read them until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            underrun   <= 1'b0;
            for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
        end else if (start_run) begin
            sample_cnt <= '0;
            underrun   <= 1'b0;
            for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
        end else begin
            if (starve) underrun <= 1'b1;
            if (take) begin
                sample_cnt <= sample_cnt + SW'(1);
                for (int i = 0; i < N_OUT; i++) begin
                    if (net_out_spikes[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        spike_cnt = '0;
        for (int i = 0; i < N_OUT; i++) spike_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end

endmodule

// File: tb/tb_spike_feeder.sv
// Directed bench for spike_feeder: default instance plus a narrow-counter instance for saturation.
module tb_spike_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        wr_valid, wr_ready, net_ready, net_sample, net_start, net_sample_ready;
    logic        frame_done, underrun;
    logic [3:0]  wr_data, net_in_spikes;
    logic [1:0]  net_out_spikes;
    logic [15:0] spike_cnt;

    logic        s_wr_valid, s_wr_ready, s_net_ready, s_net_sample, s_net_start, s_net_sample_ready;
    logic        s_frame_done, s_underrun;
    logic [3:0]  s_wr_data, s_net_in_spikes;
    logic [1:0]  s_net_out_spikes;
    logic [3:0]  s_spike_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;

    spike_feeder u_dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .net_ready(net_ready), .net_sample(net_sample), .net_out_spikes(net_out_spikes),
        .net_start(net_start), .net_sample_ready(net_sample_ready), .net_in_spikes(net_in_spikes),
        .frame_done(frame_done), .spike_cnt(spike_cnt), .underrun(underrun)
    );

    spike_feeder #(.CNT_W(2), .FRAME_LEN(5)) u_sat (
        .clk(clk), .rst_n(rst_n), .wr_valid(s_wr_valid), .wr_data(s_wr_data), .wr_ready(s_wr_ready),
        .net_ready(s_net_ready), .net_sample(s_net_sample), .net_out_spikes(s_net_out_spikes),
        .net_start(s_net_start), .net_sample_ready(s_net_sample_ready),
        .net_in_spikes(s_net_in_spikes), .frame_done(s_frame_done), .spike_cnt(s_spike_cnt),
        .underrun(s_underrun)
    );

    always @(posedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

    task automatic apply_reset();
        rst_n = 1'b0;
        wr_valid = 0; wr_data = 0; net_ready = 0; net_sample = 0; net_out_spikes = 0;
        s_wr_valid = 0; s_wr_data = 0; s_net_ready = 0; s_net_sample = 0; s_net_out_spikes = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input logic [3:0] v);
        wr_valid = 1'b1;
        wr_data  = v;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Waits (bounded) for a running frame, idles gap cycles, checks the head, then samples once.
    task automatic pulse(input logic [1:0] spk, input logic [3:0] exp_head, input int gap);
        for (int i = 0; i < 40 && net_start !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (net_start !== 1'b1) begin
            n_fail++;
            $display("FAIL pulse_wait_start: net_start=%b required 1", net_start);
        end
        repeat (gap) @(negedge clk);
        n_checks++;
        if (net_in_spikes !== exp_head) begin
            n_fail++;
            $display("FAIL pulse_head: net_in_spikes=%h required %h", net_in_spikes, exp_head);
        end
        net_sample     = 1'b1;
        net_out_spikes = spk;
        @(negedge clk);
        net_sample     = 1'b0;
        net_out_spikes = 2'b00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_valid = 0; wr_data = 0; net_ready = 0; net_sample = 0; net_out_spikes = 0;
        s_wr_valid = 0; s_wr_data = 0; s_net_ready = 0; s_net_sample = 0; s_net_out_spikes = 0;
        #12;
        n_checks++;
        if ({wr_ready, net_start, net_sample_ready, frame_done, underrun} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_flags: {wr_ready,start,srdy,done,underrun}=%b required 10000",
                     {wr_ready, net_start, net_sample_ready, frame_done, underrun});
        end
        n_checks++;
        if ({spike_cnt, net_in_spikes} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_data: spike_cnt=%h in_spikes=%h required 0", spike_cnt, net_in_spikes);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        int f0;
        push(4'hF);
        n_checks++;
        if (net_sample_ready !== 1'b1 || net_in_spikes !== 4'hF) begin
            n_fail++;
            $display("FAIL push_latency: srdy=%b head=%h required 1 F", net_sample_ready, net_in_spikes);
        end
        push(4'hE);
        push(4'hD);
        f0 = fd_cnt;
        net_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (net_start !== 1'b1) begin
            n_fail++;
            $display("FAIL start_latency: net_start=%b required 1", net_start);
        end
        pulse(2'b01, 4'hF, 9);
        pulse(2'b01, 4'hE, 9);
        pulse(2'b01, 4'hD, 9);
        n_checks++;
        if (frame_done !== 1'b1 || net_start !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: frame_done=%b net_start=%b required 1 0", frame_done, net_start);
        end
        net_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (spike_cnt !== 16'h0003 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_counts: spike_cnt=%h frame_done=%b required 0003 0", spike_cnt, frame_done);
        end
        n_checks++;
        if (fd_cnt - f0 !== 1) begin
            n_fail++;
            $display("FAIL basic_done_pulses: got %0d required 1", fd_cnt - f0);
        end
    endtask

    task automatic test_fifo_full();
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (wr_ready !== (i < 8)) begin
                n_fail++;
                $display("FAIL full_wr_ready[%0d]: wr_ready=%b required %b", i, wr_ready, (i < 8));
            end
            push(4'(i + 1));
        end
        net_ready = 1'b1;
        for (int i = 0; i < 8; i++) pulse(2'b00, 4'(i + 1), 2);
        n_checks++;
        if (net_sample_ready !== 1'b0 || net_in_spikes !== 4'h0) begin
            n_fail++;
            $display("FAIL full_drop: srdy=%b head=%h required 0 0", net_sample_ready, net_in_spikes);
        end
        net_ready = 1'b0;
    endtask

    task automatic test_underrun();
        int f0;
        apply_reset();
        push(4'hA);
        f0 = fd_cnt;
        net_ready = 1'b1;
        pulse(2'b10, 4'hA, 1);
        pulse(2'b10, 4'h0, 1);
        n_checks++;
        if (underrun !== 1'b1 || net_start !== 1'b1 || spike_cnt !== 16'h0100) begin
            n_fail++;
            $display("FAIL underrun_flag: underrun=%b start=%b spike_cnt=%h required 1 1 0100",
                     underrun, net_start, spike_cnt);
        end
        push(4'hB);
        push(4'hC);
        n_checks++;
        if (fd_cnt - f0 !== 0) begin
            n_fail++;
            $display("FAIL underrun_no_done: got %0d required 0", fd_cnt - f0);
        end
        pulse(2'b10, 4'hB, 1);
        pulse(2'b10, 4'hC, 1);
        n_checks++;
        if (frame_done !== 1'b1 || spike_cnt !== 16'h0300 || underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_finish: done=%b spike_cnt=%h underrun=%b required 1 0300 1",
                     frame_done, spike_cnt, underrun);
        end
        net_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        push(4'h5);
        net_ready = 1'b1;
        pulse(2'b01, 4'h5, 1);
        pulse(2'b01, 4'h0, 1);
        push(4'h6);
        n_checks++;
        if (spike_cnt !== 16'h0001 || underrun !== 1'b1 || net_start !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_pre: spike_cnt=%h underrun=%b start=%b required 0001 1 1",
                     spike_cnt, underrun, net_start);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({net_start, wr_ready, underrun, net_sample_ready} !== 4'b0100 || spike_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL midrun_reset: {start,wr_rdy,underrun,srdy}=%b spike_cnt=%h required 0100 0000",
                     {net_start, wr_ready, underrun, net_sample_ready}, spike_cnt);
        end
        net_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            s_wr_valid = 1'b1;
            s_wr_data  = 4'(i + 3);
            @(negedge clk);
        end
        s_wr_valid  = 1'b0;
        s_net_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 40 && s_net_start !== 1'b1; i++) @(negedge clk);
            s_net_sample     = 1'b1;
            s_net_out_spikes = 2'b11;
            @(negedge clk);
            s_net_sample     = 1'b0;
            s_net_out_spikes = 2'b00;
            if (k == 1) begin
                n_checks++;
                if (s_spike_cnt !== 4'hA) begin
                    n_fail++;
                    $display("FAIL sat_mid: spike_cnt=%h required A", s_spike_cnt);
                end
            end
        end
        n_checks++;
        if (s_frame_done !== 1'b1 || s_spike_cnt !== 4'hF) begin
            n_fail++;
            $display("FAIL sat_final: done=%b spike_cnt=%h required 1 F", s_frame_done, s_spike_cnt);
        end
        s_net_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int f0;
        apply_reset();
        for (int i = 1; i <= 6; i++) push(4'(i));
        f0 = fd_cnt;
        net_ready = 1'b1;
        pulse(2'b01, 4'h1, 1);
        pulse(2'b01, 4'h2, 1);
        pulse(2'b01, 4'h3, 1);
        n_checks++;
        if (frame_done !== 1'b1 || spike_cnt !== 16'h0003) begin
            n_fail++;
            $display("FAIL b2b_first: done=%b spike_cnt=%h required 1 0003", frame_done, spike_cnt);
        end
        pulse(2'b10, 4'h4, 1);
        n_checks++;
        if (spike_cnt !== 16'h0100) begin
            n_fail++;
            $display("FAIL b2b_cleared: spike_cnt=%h required 0100", spike_cnt);
        end
        pulse(2'b10, 4'h5, 1);
        pulse(2'b10, 4'h6, 1);
        net_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (spike_cnt !== 16'h0300 || fd_cnt - f0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_second: spike_cnt=%h done_pulses=%0d required 0300 2", spike_cnt, fd_cnt - f0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_fifo_full();
        test_underrun();
        test_reset_mid_run();
        test_saturate();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
